// File: rtl/game_display_ctrl_pkg.sv
// game_pkg: shared timer state encoding and display-range helpers.
package game_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [5:0] DISP_MAX = 6'd50;

    function automatic logic [5:0] sat50(input logic [5:0] v);
        return v > DISP_MAX ? DISP_MAX : v;
    endfunction
endpackage

// File: rtl/game_display_ctrl_if.sv
// game_display_ctrl_if: game-FSM controls in, decoder-facing display signals out.
interface game_display_ctrl_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic       score_req;
    logic [5:0] score;
    logic [5:0] disp_val;
    logic       disp_blank;
    logic       showing_score;
    logic       running;
    logic       timeout;

    modport master (
        output start, pause, abort, score_req, score,
        input  disp_val, disp_blank, showing_score, running, timeout
    );
    modport slave (
        input  start, pause, abort, score_req, score,
        output disp_val, disp_blank, showing_score, running, timeout
    );
endinterface

// File: rtl/game_display_ctrl_tick_gen.sv
// tick_gen: prescaler counting 0..DIV-1 with enable and clear; tick marks the wrap cycle.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;

    assign tick = en && !clr && cnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/game_display_ctrl.sv
// game_display_ctrl: countdown timer, score/timer arbitration and blink control
// for a shared two-digit 7-segment decoder.
module game_display_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int START_VAL   = 50,
    parameter int SCORE_HOLD  = 3,
    parameter int BLINK_TICKS = 1
) (
    input logic clk,
    input logic rst_n,
    game_display_ctrl_if.slave bus
);
    import game_pkg::*;

    localparam int HW = $clog2(SCORE_HOLD + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic [1:0]    state, state_d;
    logic [5:0]    count, count_d, score_q, score_d;
    logic [HW-1:0] hold, hold_d;
    logic [BW-1:0] blink, blink_d;
    logic          phase, phase_d, timeout_d;
    logic          active, tick, free_tick, hold_tick, blink_wrap;

    assign active = state == S_RUN || state == S_DONE;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk(clk), .rst_n(rst_n), .en(active), .clr(bus.start), .tick(tick)
    );
    // The hold must expire even while the countdown prescaler is frozen.
    tick_gen #(.DIV(TICK_DIV)) u_free (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .tick(free_tick)
    );

    assign hold_tick  = active ? tick : free_tick;
    assign blink_wrap = blink == BW'(BLINK_TICKS - 1);

    always_comb begin
        state_d   = state;
        count_d   = count;
        timeout_d = 1'b0;
        if (bus.start) begin
            state_d = S_RUN;
            count_d = sat50(6'(START_VAL));
        end else if (bus.abort) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (state == S_RUN) begin
            if (tick && count <= 6'd1) begin
                state_d   = S_DONE;
                count_d   = '0;
                timeout_d = 1'b1;
            end else begin
                count_d = tick ? count - 6'd1 : count;
                state_d = bus.pause ? S_PAUSE : S_RUN;
            end
        end else if (state == S_PAUSE && !bus.pause) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        hold_d  = hold;
        score_d = score_q;
        if (timeout_d) hold_d = '0;
        else if (bus.score_req) begin
            hold_d  = HW'(SCORE_HOLD);
            score_d = sat50(bus.score);
        end else if (hold != '0 && hold_tick) hold_d = hold - HW'(1);
    end

    // Blink phase restarts unblanked whenever DONE is entered.
    always_comb begin
        blink_d = blink;
        phase_d = phase;
        if (state != S_DONE || state_d != S_DONE) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            blink_d = blink_wrap ? '0 : blink + BW'(1);
            phase_d = blink_wrap ? !phase : phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            count             <= '0;
            hold              <= '0;
            score_q           <= '0;
            blink             <= '0;
            phase             <= 1'b0;
            bus.disp_val      <= '0;
            bus.disp_blank    <= 1'b0;
            bus.showing_score <= 1'b0;
            bus.running       <= 1'b0;
            bus.timeout       <= 1'b0;
        end else begin
            state             <= state_d;
            count             <= count_d;
            hold              <= hold_d;
            score_q           <= score_d;
            blink             <= blink_d;
            phase             <= phase_d;
            bus.disp_val      <= hold_d != '0 ? score_d : count_d;
            bus.disp_blank    <= phase_d;
            bus.showing_score <= hold_d != '0;
            bus.running       <= state_d == S_RUN || state_d == S_PAUSE;
            bus.timeout       <= timeout_d;
        end
    end
endmodule

// File: tb/tb_game_display_ctrl.sv
// tb_game_display_ctrl: vector table for countdown/blink/restart plus directed
// sequences for pause, score hold, collisions and async reset.
module tb_game_display_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_display_ctrl_if bus();
    game_display_ctrl_if bus2();

    assign bus2.start     = bus.start;
    assign bus2.pause     = 1'b0;
    assign bus2.abort     = 1'b0;
    assign bus2.score_req = 1'b0;
    assign bus2.score     = 6'd0;

    game_display_ctrl #(.TICK_DIV(4), .START_VAL(5), .SCORE_HOLD(2), .BLINK_TICKS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    game_display_ctrl #(.TICK_DIV(4), .START_VAL(50), .SCORE_HOLD(2), .BLINK_TICKS(1)) dut50 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    typedef struct {
        logic       start, pause, abort, score_req;
        logic [5:0] score;
        logic [5:0] dv;
        logic       blank, show, run, to;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int dv, input int blank, input int show,
                           input int run, input int to);
        chk({tag, ".disp_val"}, bus.disp_val, dv);
        chk({tag, ".disp_blank"}, bus.disp_blank, blank);
        chk({tag, ".showing_score"}, bus.showing_score, show);
        chk({tag, ".running"}, bus.running, run);
        chk({tag, ".timeout"}, bus.timeout, to);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 29; i++) begin
            tbl[i] = '{default: '0};
            tbl[i].start = i == 0;
            tbl[i].dv    = i < 20 ? 6'(5 - i / 4) : 6'd0;
            tbl[i].run   = i < 20;
            tbl[i].to    = i == 20;
            tbl[i].blank = i >= 24 && i <= 27;
        end
        tbl[29] = '{default: '0};
        tbl[29].start = 1'b1;
        tbl[29].abort = 1'b1;
        tbl[29].dv    = 6'd5;
        tbl[29].run   = 1'b1;

        bus.start = 0; bus.pause = 0; bus.abort = 0; bus.score_req = 0; bus.score = 0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        #10 rst_n = 1'b1;
        step();
        chk_all("idle", 0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            bus.start = tbl[i].start;
            bus.pause = tbl[i].pause;
            bus.abort = tbl[i].abort;
            bus.score_req = tbl[i].score_req;
            bus.score = tbl[i].score;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].dv, tbl[i].blank, tbl[i].show, tbl[i].run, tbl[i].to);
        end
        bus.start = 0; bus.abort = 0;

        // Pause at count 3 with the prescaler two steps into its period.
        repeat (10) step();
        chk("pause.pre", bus.disp_val, 3);
        bus.pause = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("pause.hold", bus.disp_val, 3);
            chk("pause.running", bus.running, 1);
        end
        bus.pause = 0;
        step();
        chk("pause.resume", bus.disp_val, 3);
        step();
        chk("pause.decrement", bus.disp_val, 2);

        // Score at the 5->4 tick holds for two ticks, then a score on the final tick is dropped.
        bus.start = 1;
        step();
        bus.start = 0;
        chk("score.start", bus.disp_val, 5);
        chk("start50", bus2.disp_val, 50);
        repeat (3) step();
        bus.score = 6'd37; bus.score_req = 1;
        step();
        bus.score_req = 0;
        chk("score.show", bus.showing_score, 1);
        chk("score.val", bus.disp_val, 37);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("score.held", bus.showing_score, 1);
            chk("score.heldval", bus.disp_val, 37);
        end
        step();
        chk_all("score.end", 2, 0, 0, 1, 0);
        repeat (7) step();
        chk("final.pre", bus.disp_val, 1);
        bus.score = 6'd9; bus.score_req = 1;
        step();
        bus.score_req = 0;
        chk_all("final.timeout", 0, 0, 0, 0, 1);
        step();
        chk_all("final.after", 0, 0, 0, 0, 0);

        // Retrigger during hold restarts it; 63 saturates to 50.
        bus.start = 1;
        step();
        bus.start = 0;
        repeat (3) step();
        bus.score = 6'd37; bus.score_req = 1;
        step();
        bus.score_req = 0;
        chk("retrig.first", bus.disp_val, 37);
        repeat (5) step();
        chk("retrig.t9", bus.showing_score, 1);
        bus.score = 6'd63; bus.score_req = 1;
        step();
        bus.score_req = 0;
        chk("sat.val", bus.disp_val, 50);
        repeat (2) step();
        chk("retrig.t12.show", bus.showing_score, 1);
        chk("retrig.t12.val", bus.disp_val, 50);
        repeat (3) step();
        chk("retrig.t15", bus.showing_score, 1);
        step();
        chk_all("retrig.end", 1, 0, 0, 1, 0);
        bus.abort = 1;
        step();
        bus.abort = 0;
        chk_all("abort", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a countdown.
        bus.start = 1;
        step();
        bus.start = 0;
        repeat (5) step();
        chk("rst.pre", bus.disp_val, 4);
        #3 rst_n = 1'b0;
        #1;
        chk_all("rst.async", 0, 0, 0, 0, 0);
        chk("rst.async50", bus2.disp_val, 0);
        #2 rst_n = 1'b1;
        step();
        chk_all("rst.idle", 0, 0, 0, 0, 0);
        repeat (6) step();
        chk_all("rst.stays", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
